// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel strobe, x/y counters, sync pulses, blanking and frame tick.
// Optional build macro VGA_SYNC_REG_EN adds one register stage to hsync, vsync and video_on.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       refr_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS        = 10'(H_DISPLAY);
  localparam logic [9:0]       V_VIS        = 10'(V_DISPLAY);
  localparam logic [9:0]       V_VIS_LAST   = 10'(V_DISPLAY - 1);
  localparam logic [9:0]       H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0]       V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;

  logic w_pixel_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_hsync_n;
  logic w_vsync_n;
  logic w_video_on;

  // With CLK_DIV=1 the divider never leaves 0, so the strobe stays high.
  assign w_pixel_tick = (r_div_cnt == DIV_LAST);
  assign w_h_last     = (r_h_cnt == H_LAST);
  assign w_v_last     = (r_v_cnt == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_pixel_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt <= '0;
    end else if (w_pixel_tick) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_cnt <= '0;
    end else if (w_pixel_tick && w_h_last) begin
      if (w_v_last) begin
        r_v_cnt <= '0;
      end else begin
        r_v_cnt <= r_v_cnt + 10'd1;
      end
    end
  end

  assign w_hsync_n  = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt < H_SYNC_END));
  assign w_vsync_n  = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt < V_SYNC_END));
  assign w_video_on = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);

  // Fires on the last pixel of the last visible line, so sprite updates land in blanking.
  assign refr_tick  = w_pixel_tick && w_h_last && (r_v_cnt == V_VIS_LAST);
  assign pixel_tick = w_pixel_tick;
  assign x          = r_h_cnt;
  assign y          = r_v_cnt;

`ifdef VGA_SYNC_REG_EN
  logic r_hsync;
  logic r_vsync;
  logic r_video_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
    end else begin
      r_hsync    <= w_hsync_n;
      r_vsync    <= w_vsync_n;
      r_video_on <= w_video_on;
    end
  end

  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
`else
  assign hsync    = w_hsync_n;
  assign vsync    = w_vsync_n;
  assign video_on = w_video_on;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (23x10 pixels, CLK_DIV=2) so whole frames fit in a short run.
module tb_vga_timing_gen;

  localparam int DIV = 2;
  localparam int HD = 16, HF = 2, HS = 3, HB = 2;
  localparam int VD = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;  // 23
  localparam int VT = VD + VF + VS + VB;  // 10
  localparam int FRAME = HT * VT * DIV;   // 460

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pixel_tick, video_on, hsync, vsync, refr_tick;
  logic [9:0] x, y;

  vga_timing_gen #(
    .CLK_DIV(DIV), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .x(x), .y(y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync), .refr_tick(refr_tick)
  );

  int checks = 0;
  int errors = 0;
  int t = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // Reference model: outputs from elapsed clocks since reset release.
  function automatic void model_at(input int tt, output int m_tick, output int mx, output int my,
                                   output int m_von, output int m_hs, output int m_vs, output int m_refr);
    int p;
    p      = tt / DIV;
    m_tick = ((tt % DIV) == DIV - 1) ? 1 : 0;
    mx     = p % HT;
    my     = (p / HT) % VT;
    m_von  = (mx < HD && my < VD) ? 1 : 0;
    m_hs   = (mx >= HD + HF && mx < HD + HF + HS) ? 0 : 1;
    m_vs   = (my >= VD + VF && my < VD + VF + VS) ? 0 : 1;
    m_refr = (m_tick == 1 && mx == HT - 1 && my == VD - 1) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t       <= 0;
      started <= 1'b1;
    end else begin
      t <= t + 1;
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    int e_tick, e_x, e_y, e_von, e_hs, e_vs, e_refr;
    int d_tick, d_x, d_y;
    if (started && !rst) begin
      model_at(t, e_tick, e_x, e_y, e_von, e_hs, e_vs, e_refr);
`ifdef VGA_SYNC_REG_EN
      if (t == 0) begin
        e_von = 0; e_hs = 1; e_vs = 1;
      end else begin
        model_at(t - 1, d_tick, d_x, d_y, e_von, e_hs, e_vs, e_refr);
        model_at(t, e_tick, e_x, e_y, d_tick, d_x, d_y, e_refr);
      end
`endif
      chk("pixel_tick", int'(pixel_tick), e_tick);
      chk("x", int'(x), e_x);
      chk("y", int'(y), e_y);
      chk("video_on", int'(video_on), e_von);
      chk("hsync", int'(hsync), e_hs);
      chk("vsync", int'(vsync), e_vs);
      chk("refr_tick", int'(refr_tick), e_refr);
    end
  end

  initial begin
    logic exp_tick [4];
    int hs_low, vs_low, von_cnt, refr_cnt, refr_t0, refr_t1;
    int prev_hs, prev_x, prev_y, prev_refr, fall_t;
    bit fall_seen, rise_seen, xwrap_seen, ywrap_seen, found;

    exp_tick = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and strobe cadence
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_refr", int'(refr_tick), 0);
      end
      chk("strobe_seq", int'(pixel_tick), int'(exp_tick[i]));
    end

    // Two full frames of line/frame timing measurements
    hs_low = 0; vs_low = 0; von_cnt = 0; refr_cnt = 0; refr_t0 = -1; refr_t1 = -1;
    prev_hs = int'(hsync); prev_x = int'(x); prev_y = int'(y); prev_refr = int'(refr_tick);
    fall_t = 0; fall_seen = 0; rise_seen = 0; xwrap_seen = 0; ywrap_seen = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_on) von_cnt++;
      if (!vsync) chk("vsync_row", (int'(y) >= VD + VF && int'(y) < VD + VF + VS) ? 1 : 0, 1);
      if (video_on) chk("von_region", (int'(x) < HD && int'(y) < VD) ? 1 : 0, 1);
      if (prev_hs == 1 && !hsync && !fall_seen) begin
        fall_seen = 1; fall_t = t;
        chk("hsync_fall_x", int'(x), HD + HF);
      end
      if (prev_hs == 0 && hsync && fall_seen && !rise_seen) begin
        rise_seen = 1;
        chk("hsync_rise_x", int'(x), HD + HF + HS);
        chk("hsync_low_clks", t - fall_t, HS * DIV);
      end
      if (prev_x == HT - 1 && int'(x) != HT - 1 && !xwrap_seen) begin
        xwrap_seen = 1;
        chk("xwrap_x", int'(x), 0);
        chk("xwrap_y", int'(y), (prev_y + 1) % VT);
      end
      if (prev_y == VT - 1 && int'(y) != VT - 1 && !ywrap_seen) begin
        ywrap_seen = 1;
        chk("ywrap_y", int'(y), 0);
      end
      if (refr_tick) begin
        refr_cnt++;
        if (refr_t0 < 0) refr_t0 = t; else refr_t1 = t;
        chk("refr_at_x", int'(x), HT - 1);
        chk("refr_at_y", int'(y), VD - 1);
      end
      if (prev_refr == 1) begin
        chk("after_refr_x", int'(x), 0);
        chk("after_refr_y", int'(y), VD);
      end
      prev_hs = int'(hsync); prev_x = int'(x); prev_y = int'(y); prev_refr = int'(refr_tick);
    end
    chk("hsync_low_2frames", hs_low, 2 * HS * DIV * VT);
    chk("vsync_low_2frames", vs_low, 2 * VS * HT * DIV);
    chk("video_on_2frames", von_cnt, 2 * HD * VD * DIV);
    chk("refr_count", refr_cnt, 2);
    chk("refr_gap", refr_t1 - refr_t0, FRAME);
    chk("edges_seen", int'(fall_seen & rise_seen & xwrap_seen & ywrap_seen), 1);

    // Mid-frame reset inside vsync low
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (int'(x) == HD + HF && int'(y) == VD + VF) found = 1;
    end
    chk("midreset_reached", int'(found), 1);
    if (found) begin
      chk("midreset_vsync_before", int'(vsync), 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midreset_x", int'(x), 0);
      chk("midreset_y", int'(y), 0);
      chk("midreset_vsync", int'(vsync), 1);
      found = 0;
      refr_t0 = -1;
      for (int i = 0; i < FRAME && !found; i++) begin
        if (refr_tick) begin
          found = 1;
          refr_t0 = t;
        end else begin
          @(negedge clk);
        end
      end
      chk("midreset_first_refr_t", refr_t0, HT * VD * DIV - 1);
    end

    repeat (50) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
